sar_ctrl_multi: RTL and testbench
=================================

# sar_ctrl_multi

Parametrised successor to the 10-bit SAR sequencer. It adds configurable resolution, configurable sample length and multi-channel scan sequencing with a start handshake, plus single-shot and continuous modes. Results leave through a registered valid/ready port with overrun detection. It sits between the analog front end (S&H, channel mux, comparator, capacitive DAC) and the digital result consumer.

## Interface
- N, 10, conversion resolution in bits (N ≥ 2)
- SAMPLE_CYCLES, 2, number of cycles sample_en is held high per conversion (≥ 1)
- CH, 4, number of analog channels (≥ 1); CW = max(1, clog2(CH))
- clk  input  1  clock; all logic is rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  level; sampled only in IDLE, begins a scan
- cont_mode  input  1  1 = continuous scans; 0 = single scan
- ch_mask  input  CH  enabled channels; latched at scan start
- comparator_out  input  1  1 = Vin ≥ Vdac(dac_code)
- dac_code  output  N  DAC trial code
- sample_en  output  1  S&H track enable
- ch_sel  output  CW  analog mux select
- busy  output  1  high in every state except IDLE
- result  output  N  converted code
- result_ch  output  CW  channel of result
- result_valid  output  1  result holds unread data
- result_ready  input  1  consumer accepts result
- overrun  output  1  sticky; an unread result was overwritten

## Operation
- States: IDLE, SAMPLE, CONV, DONE.
- Reset values: state IDLE; dac_code 0; sample_en 0; ch_sel 0; busy 0; result 0; result_ch 0; result_valid 0; overrun 0; bit index N-1; latched mask 0.
- IDLE: dac_code = 0, sample_en = 0.
  - If start = 1 and ch_mask ≠ 0: latch ch_mask and cont_mode, clear overrun, set ch_sel = lowest enabled channel, go to SAMPLE.
  - If start = 1 and ch_mask = 0: ignore start and stay in IDLE. overrun is not cleared.
- SAMPLE: sample_en = 1 and dac_code = 0 for exactly SAMPLE_CYCLES cycles. On exit, dac_code = 1 << (N-1) and bit index k = N-1. Go to CONV.
- CONV: one cycle per bit, N cycles in total.
  - Each cycle evaluates comparator_out against the current dac_code.
  - Bit k is kept if comparator_out = 1 and cleared if 0.
  - For k > 0, bit k-1 is then set and k decrements.
  - At k = 0, load result = final code and result_ch = ch_sel, and set result_valid. Go to DONE.
- DONE: one cycle. sample_en = 0; dac_code holds the final code.
  - Next channel = next higher enabled bit of the latched mask, wrapping to the lowest enabled bit.
  - If the current channel is the highest enabled channel (end of scan) and the latched cont_mode = 0: go to IDLE.
  - If end of scan and the live cont_mode = 1: re-latch ch_mask. If the new mask is 0, go to IDLE; otherwise restart from its lowest channel.
  - Otherwise: ch_sel = next channel, go to SAMPLE.
- Output port:
  - result_valid clears on a cycle with result_valid & result_ready.
  - If a new load coincides with result_valid = 1 and result_ready = 0: the new value overwrites and overrun is set.
  - A load in the same cycle as an accept is not an overrun; result_valid stays 1 with the new data.
- ch_sel changes only on the transition into SAMPLE, and is stable through SAMPLE, CONV and DONE.
- Changes to ch_mask or cont_mode mid-scan have no effect until the next scan boundary.

## Timing
- Define start high at edge 0 in IDLE. Then:
  - SAMPLE occupies cycles 1..S, where S = SAMPLE_CYCLES.
  - CONV occupies cycles S+1..S+N.
  - result_valid is high from cycle S+N+1, which is DONE.
- Conversion period = S + N + 1 cycles. In a continuous scan, the next SAMPLE starts the cycle after DONE.
- Single-channel single scan: busy is high for cycles 1..S+N+1 and IDLE resumes at cycle S+N+2.
- comparator_out is sampled on the rising edge ending each CONV cycle. The DAC and comparator must settle within one cycle.
- Reset asserted mid-conversion: all outputs go to their reset values immediately. A pending result is lost and overrun is cleared.

## Test plan
- N=10, S=2, CH=4, mask=0001, single scan, comparator modelling Vin = 0x2A5 (comparator_out = Vin ≥ dac_code) -> result = 0x2A5, result_ch = 0, result_valid at cycle 13, busy low from cycle 14.
- Same setup with mask=1010 -> two results in order: ch 1 then ch 3, 13 cycles apart; ch_sel is 1 during the first SAMPLE and 3 during the second; then IDLE.
- Comparator tied to 1 -> result = 0x3FF. Comparator tied to 0 -> result = 0x000. In both cases the dac_code trial sequence starts 0x200, then 0x300 or 0x100 respectively.
- cont_mode=1, mask=0011, result_ready held 0 -> overrun set at the second load. Lower cont_mode mid-scan -> the scan finishes, then IDLE. A new start clears overrun.
- start with mask=0000 -> stays IDLE, busy = 0. Load coinciding with result_ready = 1 -> no overrun.
- rst_n pulsed low during CONV bit 5 -> all outputs at reset values asynchronously. A subsequent start converts correctly.

Source files
------------

// File: rtl/sar_ctrl_multi.sv
// Multi-channel SAR conversion sequencer: sample/convert/done per enabled channel,
// with single or continuous scans and a registered valid/ready result port.
module sar_ctrl_multi #(
    parameter int unsigned N             = 10,
    parameter int unsigned SAMPLE_CYCLES = 2,
    parameter int unsigned CH            = 4,
    localparam int unsigned CW           = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          cont_mode_i,
    input  logic [CH-1:0] ch_mask_i,
    input  logic          comparator_out_i,
    output logic [N-1:0]  dac_code_o,
    output logic          sample_en_o,
    output logic [CW-1:0] ch_sel_o,
    output logic          busy_o,
    output logic [N-1:0]  result_o,
    output logic [CW-1:0] result_ch_o,
    output logic          result_valid_o,
    input  logic          result_ready_i,
    output logic          overrun_o
);

    localparam int unsigned KW = $clog2(N);
    localparam int unsigned SW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StSample, StConv, StDone} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  dac_q, dac_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [CH-1:0] mask_q, mask_d;
    logic          cont_q, cont_d;
    logic [KW-1:0] k_q, k_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  result_q, result_d;
    logic [CW-1:0] rch_q, rch_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;

    logic          load;
    logic          clr_ovr;
    logic [N-1:0]  trial;
    logic          has_next;
    logic [CW-1:0] next_ch;

    function automatic logic [CW-1:0] lowest_ch(input logic [CH-1:0] m);
        lowest_ch = '0;
        for (int i = int'(CH) - 1; i >= 0; i--) begin
            if (m[i]) lowest_ch = CW'(i);
        end
    endfunction

    // Next enabled channel strictly above the current one in the latched mask.
    always_comb begin
        has_next = 1'b0;
        next_ch  = ch_q;
        for (int i = int'(CH) - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ch_q))) begin
                has_next = 1'b1;
                next_ch  = CW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        dac_d   = dac_q;
        ch_d    = ch_q;
        mask_d  = mask_q;
        cont_d  = cont_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        clr_ovr = 1'b0;
        trial   = dac_q;

        unique case (state_q)
            StIdle: begin
                dac_d = '0;
                if (start_i && (ch_mask_i != '0)) begin
                    mask_d  = ch_mask_i;
                    cont_d  = cont_mode_i;
                    clr_ovr = 1'b1;
                    ch_d    = lowest_ch(ch_mask_i);
                    cnt_d   = '0;
                    state_d = StSample;
                end
            end
            StSample: begin
                dac_d = '0;
                if (cnt_q == SW'(SAMPLE_CYCLES - 1)) begin
                    dac_d[N-1] = 1'b1;
                    k_d        = KW'(N - 1);
                    state_d    = StConv;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StConv: begin
                trial[k_q] = comparator_out_i;
                if (k_q != '0) begin
                    trial[k_q - 1'b1] = 1'b1;
                    k_d               = k_q - 1'b1;
                end else begin
                    load    = 1'b1;
                    k_d     = KW'(N - 1);
                    state_d = StDone;
                end
                dac_d = trial;
            end
            StDone: begin
                dac_d = '0;
                cnt_d = '0;
                if (has_next) begin
                    ch_d    = next_ch;
                    state_d = StSample;
                end else if (cont_q && cont_mode_i) begin
                    // Scan boundary in continuous mode: pick up the live mask.
                    mask_d = ch_mask_i;
                    cont_d = cont_mode_i;
                    if (ch_mask_i != '0) begin
                        ch_d    = lowest_ch(ch_mask_i);
                        state_d = StSample;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        result_d = result_q;
        rch_d    = rch_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        if (valid_q && result_ready_i) valid_d = 1'b0;
        if (load) begin
            result_d = trial;
            rch_d    = ch_q;
            valid_d  = 1'b1;
            if (valid_q && !result_ready_i) ovr_d = 1'b1;
        end
        if (clr_ovr) ovr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            dac_q    <= '0;
            ch_q     <= '0;
            mask_q   <= '0;
            cont_q   <= 1'b0;
            k_q      <= KW'(N - 1);
            cnt_q    <= '0;
            result_q <= '0;
            rch_q    <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dac_q    <= dac_d;
            ch_q     <= ch_d;
            mask_q   <= mask_d;
            cont_q   <= cont_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rch_q    <= rch_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign dac_code_o     = dac_q;
    assign sample_en_o    = (state_q == StSample);
    assign ch_sel_o       = ch_q;
    assign busy_o         = (state_q != StIdle);
    assign result_o       = result_q;
    assign result_ch_o    = rch_q;
    assign result_valid_o = valid_q;
    assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_sar_ctrl_multi.sv
// Bench for sar_ctrl_multi: per-channel analog inputs feed a comparator model and the
// conversions are checked cycle by cycle against SAR rules derived from the expected code.
module tb_sar_ctrl_multi;

    localparam int N  = 10;
    localparam int S  = 2;
    localparam int CH = 4;
    localparam int CW = 2;
    localparam int P  = S + N + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cont_mode = 1'b0;
    logic [CH-1:0] ch_mask = '0;
    logic          comparator_out;
    logic [N-1:0]  dac_code;
    logic          sample_en;
    logic [CW-1:0] ch_sel;
    logic          busy;
    logic [N-1:0]  result;
    logic [CW-1:0] result_ch;
    logic          result_valid;
    logic          result_ready = 1'b1;
    logic          overrun;

    logic [N-1:0]  vin [CH];
    logic [1:0]    comp_mode = 2'd0;  // 0: Vin >= DAC, 1: tied high, 2: tied low

    int checks   = 0;
    int failures = 0;

    sar_ctrl_multi #(.N(N), .SAMPLE_CYCLES(S), .CH(CH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start),
        .cont_mode_i      (cont_mode),
        .ch_mask_i        (ch_mask),
        .comparator_out_i (comparator_out),
        .dac_code_o       (dac_code),
        .sample_en_o      (sample_en),
        .ch_sel_o         (ch_sel),
        .busy_o           (busy),
        .result_o         (result),
        .result_ch_o      (result_ch),
        .result_valid_o   (result_valid),
        .result_ready_i   (result_ready),
        .overrun_o        (overrun)
    );

    assign comparator_out = (comp_mode == 2'd1) ? 1'b1 :
                            (comp_mode == 2'd2) ? 1'b0 : (vin[ch_sel] >= dac_code);

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_code(input int ch);
        if (comp_mode == 2'd1) return (1 << N) - 1;
        if (comp_mode == 2'd2) return 0;
        return int'(vin[ch]);
    endfunction

    // Trial code while deciding bit k: decided upper bits of the answer plus bit k set.
    function automatic int trial_code(input int code, input int k);
        return ((code >> (k + 1)) << (k + 1)) | (1 << k);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_dac"},   32'(dac_code), 32'd0);
        check_eq({tag, "_sen"},   32'(sample_en), 32'd0);
        check_eq({tag, "_chsel"}, 32'(ch_sel), 32'd0);
        check_eq({tag, "_busy"},  32'(busy), 32'd0);
        check_eq({tag, "_res"},   32'(result), 32'd0);
        check_eq({tag, "_rch"},   32'(result_ch), 32'd0);
        check_eq({tag, "_valid"}, 32'(result_valid), 32'd0);
        check_eq({tag, "_ovr"},   32'(overrun), 32'd0);
    endtask

    task automatic do_start(input logic [CH-1:0] m, input logic c);
        @(negedge clk);
        ch_mask   = m;
        cont_mode = c;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Single scan with the consumer always ready; checks every cycle of every conversion.
    task automatic scan_single(input logic [CH-1:0] m);
        int chs[$];
        int total, j, off, ch, e;
        for (int i = 0; i < CH; i++) if (m[i]) chs.push_back(i);
        result_ready = 1'b1;
        do_start(m, 1'b0);
        total = chs.size() * P;
        for (int c = 1; c <= total + 1; c++) begin
            @(negedge clk);
            if (c == 1) check_eq("start_clears_ovr", 32'(overrun), 32'd0);
            if (c == total + 1) begin
                check_eq("end_busy", 32'(busy), 32'd0);
                check_eq("end_sen", 32'(sample_en), 32'd0);
                check_eq("end_ovr", 32'(overrun), 32'd0);
            end else begin
                j   = (c - 1) / P;
                off = (c - 1) % P;
                ch  = chs[j];
                e   = exp_code(ch);
                check_eq("ch_sel", 32'(ch_sel), 32'(ch));
                check_eq("busy", 32'(busy), 32'd1);
                check_eq("sample_en", 32'(sample_en), 32'(off < S));
                if (off < S) check_eq("dac_sample", 32'(dac_code), 32'd0);
                if (off >= S && off < S + N)
                    check_eq("dac_trial", 32'(dac_code), 32'(trial_code(e, N - 1 - (off - S))));
                if (off == P - 1) begin
                    check_eq("valid", 32'(result_valid), 32'd1);
                    check_eq("result", 32'(result), 32'(e));
                    check_eq("result_ch", 32'(result_ch), 32'(ch));
                    check_eq("dac_done", 32'(dac_code), 32'(e));
                end
                if (off == 0 && c > 1) check_eq("valid_accepted", 32'(result_valid), 32'd0);
            end
        end
    endtask

    // Two-channel single scan: ready rises just before the second load, so no overrun.
    task automatic load_with_accept();
        result_ready = 1'b0;
        comp_mode    = 2'd0;
        do_start(4'b0011, 1'b0);
        for (int c = 1; c <= 2 * P + 1; c++) begin
            @(negedge clk);
            if (c == P) begin
                check_eq("la_valid1", 32'(result_valid), 32'd1);
                check_eq("la_ovr1", 32'(overrun), 32'd0);
            end
            if (c == 2 * P - 1) result_ready = 1'b1;
            if (c == 2 * P) begin
                check_eq("la_valid2", 32'(result_valid), 32'd1);
                check_eq("la_res2", 32'(result), 32'(vin[1]));
                check_eq("la_rch2", 32'(result_ch), 32'd1);
                check_eq("la_ovr2", 32'(overrun), 32'd0);
            end
            if (c == 2 * P + 1) begin
                check_eq("la_valid_clr", 32'(result_valid), 32'd0);
                check_eq("la_idle", 32'(busy), 32'd0);
            end
        end
    endtask

    // Continuous scan of ch0/ch1 with nobody reading; cont_mode drops during the second scan.
    task automatic cont_overrun();
        result_ready = 1'b0;
        comp_mode    = 2'd0;
        do_start(4'b0011, 1'b1);
        for (int c = 1; c <= 4 * P + 1; c++) begin
            @(negedge clk);
            if (c == P) begin
                check_eq("co_res1", 32'(result), 32'(vin[0]));
                check_eq("co_ovr1", 32'(overrun), 32'd0);
            end
            if (c == 2 * P) begin
                check_eq("co_res2", 32'(result), 32'(vin[1]));
                check_eq("co_rch2", 32'(result_ch), 32'd1);
                check_eq("co_ovr2", 32'(overrun), 32'd1);
            end
            if (c == 2 * P + 1) begin
                check_eq("co_restart_ch", 32'(ch_sel), 32'd0);
                check_eq("co_restart_busy", 32'(busy), 32'd1);
                check_eq("co_restart_sen", 32'(sample_en), 32'd1);
            end
            if (c == 2 * P + 3) cont_mode = 1'b0;
            if (c == 3 * P) check_eq("co_res3", 32'(result), 32'(vin[0]));
            if (c == 4 * P) begin
                check_eq("co_res4", 32'(result), 32'(vin[1]));
                check_eq("co_busy4", 32'(busy), 32'd1);
            end
            if (c == 4 * P + 1) begin
                check_eq("co_idle", 32'(busy), 32'd0);
                check_eq("co_valid_held", 32'(result_valid), 32'd1);
                check_eq("co_ovr_sticky", 32'(overrun), 32'd1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < CH; i++) vin[i] = N'($urandom);

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_rst");

        comp_mode = 2'd0;
        vin[0] = 10'h2A5;
        scan_single(4'b0001);
        vin[1] = N'($urandom);
        vin[3] = N'($urandom);
        scan_single(4'b1010);
        comp_mode = 2'd1;
        scan_single(4'b0001);
        comp_mode = 2'd2;
        scan_single(4'b0001);

        comp_mode = 2'd0;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < CH; i++) vin[i] = N'($urandom);
            scan_single(CH'($urandom_range(1, (1 << CH) - 1)));
        end

        for (int i = 0; i < CH; i++) vin[i] = N'($urandom);
        load_with_accept();
        cont_overrun();

        // Start with an empty mask is ignored and leaves overrun set.
        @(negedge clk);
        ch_mask = '0;
        start   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("zm_busy", 32'(busy), 32'd0);
            check_eq("zm_sen", 32'(sample_en), 32'd0);
            check_eq("zm_ovr", 32'(overrun), 32'd1);
        end
        start = 1'b0;

        // Asynchronous reset while deciding bit 5, with a result still pending.
        vin[0] = N'($urandom);
        do_start(4'b0001, 1'b0);
        for (int c = 1; c <= S + 5; c++) @(negedge clk);
        check_eq("pre_rst_trial", 32'(dac_code), 32'(trial_code(int'(vin[0]), 5)));
        check_eq("pre_rst_valid", 32'(result_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < CH; i++) vin[i] = N'($urandom);
        scan_single(4'b0101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
